// File: rtl/ff_excitation_encoder.sv
// ff_excitation_encoder
//
// Purpose:
//   Turns a stream of desired next-state words into the per-bit excitation
//   (T, J, K) that moves a WIDTH-wide bank of tff/jkff cells from its current
//   state to each target. A shadow copy of the bank state is kept so that
//   back-to-back words are excited relative to the state the previous word
//   leaves behind.
//
// Configuration macro:
//   JK_TOGGLE_EN - when defined, the J/K don't-cares are filled in toggle form
//                  (J = K = q ^ d), so a jkff bank behaves as a tff bank.
//                  When undefined, minimal excitation is produced
//                  (J = d & ~q, K = ~d & q).
//
// Parameters:
//   WIDTH - bits per state word / flip-flops in the driven bank
//   INIT  - reset value of the shadow state (must equal the bank reset value)
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous, active-low reset
//   in_valid   - target word available on in_d
//   in_ready   - block accepts in_d this cycle
//   in_d       - desired next state of the bank
//   out_valid  - excitation word available
//   out_ready  - consumer accepts the excitation word
//   out_t      - T excitation (q ^ d)
//   out_j      - J excitation
//   out_k      - K excitation
//   out_nflip  - number of bits set in out_t
//   q_shadow   - bank state after all accepted words apply

module ff_excitation_encoder #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_t,
    output logic [WIDTH-1:0]           out_j,
    output logic [WIDTH-1:0]           out_k,
    output logic [$clog2(WIDTH+1)-1:0] out_nflip,
    output logic [WIDTH-1:0]           q_shadow
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             accept;
    logic [WIDTH-1:0] toggleNext;
    logic [WIDTH-1:0] jNext;
    logic [WIDTH-1:0] kNext;
    logic [CW-1:0]    flipCount;

    // The output register can take a new word whenever it is empty or its
    // current word is leaving this cycle, which gives full throughput with
    // no bubble between consecutive words.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Every bit that differs between the shadow state and the target must
    // toggle; that difference is the T excitation.
    assign toggleNext = q_shadow ^ in_d;

`ifdef JK_TOGGLE_EN
    // Don't-cares filled so that J and K both equal T.
    assign jNext = toggleNext;
    assign kNext = toggleNext;
`else
    // Minimal excitation: set only on 0->1, reset only on 1->0, don't-cares 0.
    assign jNext = in_d & ~q_shadow;
    assign kNext = ~in_d & q_shadow;
`endif

    // Population count of the toggle word; the counter is wide enough to hold
    // WIDTH itself, so an all-ones word does not wrap.
    always_comb begin
        flipCount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flipCount = flipCount + CW'(toggleNext[i]);
        end
    end

    // Output register and shadow state. A new accept always wins (it also
    // covers the transfer-and-accept case); a transfer without an accept only
    // clears the valid flag so the data outputs keep their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_t     <= '0;
            out_j     <= '0;
            out_k     <= '0;
            out_nflip <= '0;
            q_shadow  <= INIT;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_t     <= toggleNext;
            out_j     <= jNext;
            out_k     <= kNext;
            out_nflip <= flipCount;
            q_shadow  <= in_d;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ff_excitation_encoder.sv
// tb_ff_excitation_encoder
//
// Purpose:
//   Self-checking bench for ff_excitation_encoder at WIDTH=4, INIT=0.
//   Directed scenarios for reset, excitation values, back-pressure, streaming,
//   unchanged targets and reset during a stall, followed by randomized traffic.
//   Expected values come from a bit-wise flip-flop excitation model kept in
//   this file. Define JK_TOGGLE_EN for both files to exercise the toggle build.

module tb_ff_excitation_encoder;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_d;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_t;
    logic [W-1:0]  out_j;
    logic [W-1:0]  out_k;
    logic [CW-1:0] out_nflip;
    logic [W-1:0]  q_shadow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic         mValid;
    logic [W-1:0] mQ;
    logic [W-1:0] mT;
    logic [W-1:0] mJ;
    logic [W-1:0] mK;
    int           mN;

    ff_excitation_encoder #(
        .WIDTH(W),
        .INIT (4'b0000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_d     (in_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_t    (out_t),
        .out_j    (out_j),
        .out_k    (out_k),
        .out_nflip(out_nflip),
        .q_shadow (q_shadow)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mQ     = '0;
        mT     = '0;
        mJ     = '0;
        mK     = '0;
        mN     = 0;
    endtask

    // Per-bit excitation table of a flip-flop moving from q to d.
    task automatic modelLoad(input logic [W-1:0] d);
        int cnt;
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            logic qb, db, tb, jb, kb;
            qb = mQ[i];
            db = d[i];
            tb = (qb != db);
`ifdef JK_TOGGLE_EN
            jb = tb;
            kb = tb;
`else
            if (!qb && db) begin
                jb = 1'b1; kb = 1'b0;
            end else if (qb && !db) begin
                jb = 1'b0; kb = 1'b1;
            end else begin
                jb = 1'b0; kb = 1'b0;
            end
`endif
            mT[i] = tb;
            mJ[i] = jb;
            mK[i] = kb;
            if (tb) cnt++;
        end
        mN     = cnt;
        mValid = 1'b1;
        mQ     = d;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(mValid));
        checkOutput({tag, "_t"},     32'(out_t),     32'(mT));
        checkOutput({tag, "_j"},     32'(out_j),     32'(mJ));
        checkOutput({tag, "_k"},     32'(out_k),     32'(mK));
        checkOutput({tag, "_nflip"}, 32'(out_nflip), 32'(mN));
        checkOutput({tag, "_q"},     32'(q_shadow),  32'(mQ));
    endtask

    // Drive one cycle of inputs (called right after a falling edge), check the
    // combinational ready, advance the model at the rising edge and compare
    // all registered outputs at the following falling edge.
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [W-1:0] d, input logic r);
        logic acc;
        in_valid  = v;
        in_d      = d;
        out_ready = r;
        #1;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(!mValid || r));
        acc = v && (!mValid || r);
        @(posedge clk);
        if (acc) modelLoad(d);
        else if (mValid && r) mValid = 1'b0;
        @(negedge clk);
        checkAll(tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_d      = '0;
        out_ready = 1'b1;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll("reset");
        reset_n = 1'b1;

        // 1: first word excited from 0000
        applyStimulus("s1", 1'b1, 4'b1010, 1'b1);
        checkOutput("s1_t_const", 32'(out_t), 32'h0000000A);
        checkOutput("s1_nflip_const", 32'(out_nflip), 32'd2);
        checkOutput("s1_q_const", 32'(q_shadow), 32'h0000000A);

        // 2: second word excited from 1010
        applyStimulus("s2", 1'b1, 4'b0110, 1'b1);
        checkOutput("s2_t_const", 32'(out_t), 32'h0000000C);
`ifdef JK_TOGGLE_EN
        checkOutput("s2_j_const", 32'(out_j), 32'h0000000C);
        checkOutput("s2_k_const", 32'(out_k), 32'h0000000C);
`else
        checkOutput("s2_j_const", 32'(out_j), 32'h00000004);
        checkOutput("s2_k_const", 32'(out_k), 32'h00000008);
`endif

        // 3: back-pressure for three cycles with a pending word, then release
        for (int i = 0; i < 3; i++) begin
            applyStimulus("s3_hold", 1'b1, 4'b0011, 1'b0);
            checkOutput("s3_hold_q_const", 32'(q_shadow), 32'h00000006);
        end
        applyStimulus("s3_release", 1'b1, 4'b0011, 1'b1);
        checkOutput("s3_release_q_const", 32'(q_shadow), 32'h00000003);

        // 4: stream from 0000 with every bit flipping each word
        applyStimulus("s4_pre", 1'b1, 4'b0000, 1'b1);
        applyStimulus("s4_a", 1'b1, 4'b1111, 1'b1);
        checkOutput("s4_a_nflip_const", 32'(out_nflip), 32'd4);
        applyStimulus("s4_b", 1'b1, 4'b0000, 1'b1);
        checkOutput("s4_b_nflip_const", 32'(out_nflip), 32'd4);
        applyStimulus("s4_c", 1'b1, 4'b1111, 1'b1);
        checkOutput("s4_c_nflip_const", 32'(out_nflip), 32'd4);
        checkOutput("s4_c_t_const", 32'(out_t), 32'h0000000F);

        // 5: target equal to the current state is still emitted
        applyStimulus("s5_pre", 1'b1, 4'b0110, 1'b1);
        applyStimulus("s5", 1'b1, 4'b0110, 1'b1);
        checkOutput("s5_valid_const", 32'(out_valid), 32'd1);
        checkOutput("s5_t_const", 32'(out_t), 32'd0);
        checkOutput("s5_nflip_const", 32'(out_nflip), 32'd0);

        // 6: asynchronous reset while stalled
        applyStimulus("s6_pre", 1'b1, 4'b1001, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("s6_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("s6_rst_q", 32'(q_shadow), 32'd0);
        checkOutput("s6_rst_t", 32'(out_t), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("s6_post", 1'b1, 4'b0101, 1'b1);
        checkOutput("s6_post_t_const", 32'(out_t), 32'h00000005);

        // Randomized traffic with random valid and back-pressure
        for (int n = 0; n < 300; n++) begin
            applyStimulus("rnd", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
